// File: rtl/dsp_config_loader.sv
// dsp_config_loader
//   Loads the serial configuration chain of a DSP tile/column from a host.
//   Host words arrive over a valid/ready handshake. They are serialised MSB-first
//   into the chain during LOAD. The chain is then recirculated once in VERIFY,
//   and a CRC-16-CCITT of the returned stream is compared with the CRC of the
//   loaded stream.
//
// Ports
//   clk, RSTN                 clock, asynchronous active-low reset
//   start, abort              load request (IDLE only) / synchronous abort
//   cfg_word/valid/ready      host word handshake
//   configuration_input       serial data to the chain head
//   configuration_enable      chain shift enable
//   configuration_output      serial data from the chain tail
//   busy, done, crc_error     status (done pulses once; crc_error is sticky)
//   bit_count                 bits shifted in the current phase
module dsp_config_loader #(
  parameter int WORD_W    = 16,
  parameter int CHAIN_LEN = 64,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              RSTN,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] cfg_word,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              configuration_input,
  output logic              configuration_enable,
  input  logic              configuration_output,
  output logic              busy,
  output logic              done,
  output logic              crc_error,
  output logic [CNT_W-1:0]  bit_count
);

  localparam int N_WORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int SH_W    = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CHAIN_LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_VERIFY} state_t;

  state_t            state_q;
  logic [WORD_W-1:0] hold_q;
  logic              hold_valid_q;
  logic [WORD_W-1:0] shreg_q;
  logic [SH_W-1:0]   sh_cnt_q;      // bits still waiting in shreg_q
  logic [CNT_W-1:0]  words_q;       // words accepted in this load
  logic [CNT_W-1:0]  bit_count_q;
  logic [15:0]       crc_load_q;
  logic [15:0]       crc_ver_q;
  logic              cin_q;
  logic              cen_q;
  logic              done_q;
  logic              crc_error_q;

  function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic b);
    logic fb;
    fb = crc[15] ^ b;
    return {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  logic             hs;
  logic             direct;         // accepted word goes straight to the shifter
  logic             last_shift;     // this edge shifts the final LOAD bit in
  logic             can_issue;
  logic [CNT_W-1:0] issued;         // bits shifted plus the one on the wire
  logic [15:0]      crc_load_d;
  logic [15:0]      crc_ver_d;

  assign cfg_ready  = (state_q == S_LOAD) && !hold_valid_q && (words_q < CNT_W'(N_WORDS));
  assign hs         = cfg_valid && cfg_ready;
  assign direct     = hs && (sh_cnt_q == '0);
  assign issued     = bit_count_q + CNT_W'(cen_q);
  assign can_issue  = issued < CNT_W'(CHAIN_LEN);
  assign last_shift = cen_q && (bit_count_q == LAST);
  assign crc_load_d = crc_step(crc_load_q, cin_q);
  assign crc_ver_d  = crc_step(crc_ver_q, configuration_output);

  // During VERIFY the tail feeds the head directly, so the loop adds no flop.
  assign configuration_input  = (state_q == S_VERIFY) ? configuration_output : cin_q;
  assign configuration_enable = cen_q;
  assign busy                 = (state_q != S_IDLE);
  assign done                 = done_q;
  assign crc_error            = crc_error_q;
  assign bit_count            = bit_count_q;

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      state_q      <= S_IDLE;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      shreg_q      <= '0;
      sh_cnt_q     <= '0;
      words_q      <= '0;
      bit_count_q  <= '0;
      crc_load_q   <= 16'hFFFF;
      crc_ver_q    <= 16'hFFFF;
      cin_q        <= 1'b0;
      cen_q        <= 1'b0;
      done_q       <= 1'b0;
      crc_error_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort) begin
        state_q      <= S_IDLE;
        cen_q        <= 1'b0;
        cin_q        <= 1'b0;
        hold_valid_q <= 1'b0;
        sh_cnt_q     <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start) begin
              state_q      <= S_LOAD;
              crc_error_q  <= 1'b0;
              bit_count_q  <= '0;
              crc_load_q   <= 16'hFFFF;
              crc_ver_q    <= 16'hFFFF;
              hold_valid_q <= 1'b0;
              sh_cnt_q     <= '0;
              words_q      <= '0;
            end
          end
          S_LOAD: begin
            if (cen_q) begin
              crc_load_q  <= crc_load_d;
              bit_count_q <= bit_count_q + CNT_W'(1);
            end
            if (hs) begin
              words_q <= words_q + CNT_W'(1);
            end
            if (hs && !direct) begin
              hold_q       <= cfg_word;
              hold_valid_q <= 1'b1;
            end
            if (last_shift) begin
              // Enable stays high so VERIFY follows LOAD without a gap.
              state_q     <= S_VERIFY;
              bit_count_q <= '0;
              cen_q       <= 1'b1;
              cin_q       <= 1'b0;
            end else if (can_issue && (sh_cnt_q != '0)) begin
              cin_q    <= shreg_q[WORD_W-1];
              shreg_q  <= shreg_q << 1;
              sh_cnt_q <= sh_cnt_q - SH_W'(1);
              cen_q    <= 1'b1;
            end else if (can_issue && hold_valid_q) begin
              cin_q        <= hold_q[WORD_W-1];
              shreg_q      <= hold_q << 1;
              sh_cnt_q     <= SH_W'(WORD_W - 1);
              hold_valid_q <= 1'b0;
              cen_q        <= 1'b1;
            end else if (can_issue && direct) begin
              cin_q    <= cfg_word[WORD_W-1];
              shreg_q  <= cfg_word << 1;
              sh_cnt_q <= SH_W'(WORD_W - 1);
              cen_q    <= 1'b1;
            end else begin
              cen_q <= 1'b0;   // starved: chain holds
            end
          end
          S_VERIFY: begin
            crc_ver_q   <= crc_ver_d;
            bit_count_q <= bit_count_q + CNT_W'(1);
            if (bit_count_q == LAST) begin
              state_q     <= S_IDLE;
              cen_q       <= 1'b0;
              done_q      <= 1'b1;
              crc_error_q <= (crc_ver_d != crc_load_q);
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dsp_config_loader.sv
// Testbench for dsp_config_loader: a 40-flop chain instance driven through
// directed and randomized loads, plus a 1-flop chain instance.
module tb_dsp_config_loader;

  localparam int L = 40;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        RSTN, start, abort, cfg_valid;
  logic [15:0] cfg_word;
  logic        cfg_ready, cin, cen, cout, busy, done, crc_error;
  logic [15:0] bit_count;

  logic        start1, abort1, cfg_valid1;
  logic [15:0] cfg_word1;
  logic        cfg_ready1, cin1, cen1, cout1, busy1, done1, crc_error1;
  logic [15:0] bit_count1;

  // Chain models: plain shift registers, first shifted bit ends at the tail.
  logic [L-1:0] chain;
  logic [L-1:0] flip_mask;
  logic         chain1;
  always @(posedge clk) begin
    if (cen) chain <= {chain[L-2:0], cin} ^ flip_mask;
    else     chain <= chain ^ flip_mask;
  end
  assign cout = chain[L-1];
  always @(posedge clk) if (cen1) chain1 <= cin1;
  assign cout1 = chain1;

  dsp_config_loader #(.WORD_W(16), .CHAIN_LEN(L), .CNT_W(16)) dut (
    .clk(clk), .RSTN(RSTN), .start(start), .abort(abort),
    .cfg_word(cfg_word), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .configuration_input(cin), .configuration_enable(cen),
    .configuration_output(cout), .busy(busy), .done(done),
    .crc_error(crc_error), .bit_count(bit_count)
  );

  dsp_config_loader #(.WORD_W(16), .CHAIN_LEN(1), .CNT_W(16)) dut1 (
    .clk(clk), .RSTN(RSTN), .start(start1), .abort(abort1),
    .cfg_word(cfg_word1), .cfg_valid(cfg_valid1), .cfg_ready(cfg_ready1),
    .configuration_input(cin1), .configuration_enable(cen1),
    .configuration_output(cout1), .busy(busy1), .done(done1),
    .crc_error(crc_error1), .bit_count(bit_count1)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One load of the 40-flop chain. Expected chain = first L bits of the word
  // stream; crc_error expected exactly when the bench corrupted the chain.
  task automatic run40(input string name, input logic [15:0] w0, input logic [15:0] w1,
                       input logic [15:0] w2, input int stall_n, input bit rnd,
                       input int flip_pos, input int abort_at, input int rst_at,
                       input bit spam);
    logic [15:0]  w [3];
    logic [47:0]  stream;
    logic [L-1:0] exp_chain, mask;
    logic [15:0]  spam_bc;
    int widx, cyc, en_cnt, dry, dones;
    bit finished, got_done, aborted, was_reset, spam_pending, gate;
    w[0] = w0; w[1] = w1; w[2] = w2;
    stream    = {w0, w1, w2};
    exp_chain = stream[47:48-L];
    mask      = '0;
    if (flip_pos >= 0) mask[flip_pos] = 1'b1;
    widx = 0; cyc = 0; en_cnt = 0; dry = 0; dones = 0; spam_bc = '0;
    finished = 0; got_done = 0; aborted = 0; was_reset = 0; spam_pending = 0;
    cfg_valid = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; cyc = 1;
    chk({name, ".busy_after_start"}, busy, 1'b1);
    chk({name, ".ready_after_start"}, cfg_ready, 1'b1);
    while (!finished) begin
      start = 1'b0;
      if (cfg_valid) widx++;
      if (spam_pending) begin
        chk({name, ".start_ignored"}, bit_count, spam_bc + 16'd1);
        spam_pending = 0;
      end
      if (cen) en_cnt++;
      if (busy && !cen && bit_count != 0) begin
        dry++;
        chk({name, ".gap_on_word_boundary"}, bit_count % 16, 0);
      end
      flip_mask = (flip_pos >= 0 && cen && en_cnt == L) ? mask : '0;
      if (done) begin
        dones++;
        got_done = 1;
        finished = 1;
        if (!rnd) chk({name, ".latency"}, cyc, 2*L + 2 + stall_n);
        chk({name, ".crc_error"}, crc_error, (flip_pos >= 0));
        chk({name, ".busy_at_done"}, busy, 1'b0);
        chk({name, ".enable_cycles"}, en_cnt, 2*L);
        chk({name, ".chain"}, chain, exp_chain ^ mask);
      end else if (abort) begin
        abort = 1'b0;
        aborted = 1;
        finished = 1;
        chk({name, ".abort_busy"}, busy, 1'b0);
        chk({name, ".abort_enable"}, cen, 1'b0);
        chk({name, ".abort_ready"}, cfg_ready, 1'b0);
        chk({name, ".abort_done"}, done, 1'b0);
      end else if (rst_at > 0 && en_cnt == rst_at) begin
        cfg_valid = 1'b0;
        was_reset = 1;
        finished = 1;
        #2 RSTN = 1'b0;
        #1;
        chk({name, ".rst_busy"}, busy, 1'b0);
        chk({name, ".rst_enable"}, cen, 1'b0);
        chk({name, ".rst_cin"}, cin, 1'b0);
        chk({name, ".rst_done"}, done, 1'b0);
        chk({name, ".rst_crc_error"}, crc_error, 1'b0);
        chk({name, ".rst_bit_count"}, bit_count, 16'd0);
      end else begin
        if (abort_at >= 0 && cen && bit_count == abort_at && en_cnt <= L) abort = 1'b1;
        if (spam && cen && (bit_count == 10 || en_cnt == L + 5)) begin
          start = 1'b1;
          spam_bc = bit_count;
          spam_pending = 1;
        end
        gate = (widx == 1 && stall_n > 0 && dry < stall_n) ||
               (rnd && $urandom_range(0, 2) == 0);
        if (widx < 3 && cfg_ready && !gate) begin
          cfg_valid = 1'b1;
          cfg_word  = w[widx];
        end else begin
          cfg_valid = 1'b0;
          cfg_word  = 16'($urandom);
        end
        @(negedge clk);
        cyc++;
        if (cyc > 400) begin
          chk({name, ".done_seen"}, dones, 1);
          finished = 1;
        end
      end
    end
    cfg_valid = 1'b0;
    abort     = 1'b0;
    start     = 1'b0;
    flip_mask = '0;
    if (aborted) begin
      repeat (3) begin
        @(negedge clk);
        chk({name, ".no_done_after_abort"}, done, 1'b0);
      end
    end
    if (got_done) begin
      @(negedge clk);
      chk({name, ".done_one_cycle"}, done, 1'b0);
      chk({name, ".crc_error_sticky"}, crc_error, (flip_pos >= 0));
    end
    if (was_reset) begin
      @(negedge clk);
      RSTN = 1'b1;
      @(negedge clk);
      chk({name, ".idle_after_reset"}, busy, 1'b0);
    end
    $display("run %-12s cycles=%0d enables=%0d done=%0b crc_error=%0b",
             name, cyc, en_cnt, got_done, crc_error);
  endtask

  // One load of the 1-flop chain: only the MSB of the single word survives.
  task automatic run1(input string name, input logic [15:0] w);
    int cyc, en_cnt;
    bit sent, finished;
    cyc = 0; en_cnt = 0; sent = 0; finished = 0;
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0; cyc = 1;
    while (!finished) begin
      if (cfg_valid1) sent = 1;
      if (cen1) en_cnt++;
      if (done1) begin
        finished = 1;
        chk({name, ".latency"}, cyc, 4);
        chk({name, ".enable_cycles"}, en_cnt, 2);
        chk({name, ".chain"}, chain1, w[15]);
        chk({name, ".crc_error"}, crc_error1, 1'b0);
      end else begin
        cfg_valid1 = (!sent && cfg_ready1);
        cfg_word1  = w;
        @(negedge clk);
        cyc++;
        if (cyc > 20) begin
          chk({name, ".done_seen"}, done1, 1'b1);
          finished = 1;
        end
      end
    end
    cfg_valid1 = 1'b0;
    $display("run %-12s cycles=%0d enables=%0d chain=%0b crc_error=%0b",
             name, cyc, en_cnt, chain1, crc_error1);
  endtask

  initial begin
    RSTN = 1'b1; start = 1'b0; abort = 1'b0; cfg_valid = 1'b0; cfg_word = '0;
    start1 = 1'b0; abort1 = 1'b0; cfg_valid1 = 1'b0; cfg_word1 = '0;
    flip_mask = '0;
    #1 RSTN = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset.busy", busy, 1'b0);
    chk("reset.ready", cfg_ready, 1'b0);
    chk("reset.enable", cen, 1'b0);
    chk("reset.cin", cin, 1'b0);
    chk("reset.done", done, 1'b0);
    chk("reset.crc_error", crc_error, 1'b0);
    chk("reset.bit_count", bit_count, 16'd0);
    chk("reset.busy1", busy1, 1'b0);
    RSTN = 1'b1;
    @(negedge clk);
    chk("idle.ready", cfg_ready, 1'b0);

    run40("basic",     16'hA5C3, 16'h0F0F, 16'h1234, 0, 0, -1, -1, -1, 1);
    run40("stall3",    16'hA5C3, 16'h0F0F, 16'h1234, 3, 0, -1, -1, -1, 0);
    run40("flip7",     16'hA5C3, 16'h0F0F, 16'h1234, 0, 0,  7, -1, -1, 0);
    run40("abort20",   16'hA5C3, 16'h0F0F, 16'h1234, 0, 0, -1, 20, -1, 0);
    run40("reload",    16'hA5C3, 16'h0F0F, 16'h1234, 0, 0, -1, -1, -1, 0);
    run40("rst_verify",16'hA5C3, 16'h0F0F, 16'h1234, 0, 0, -1, -1, L + 10, 0);
    run40("after_rst", 16'($urandom), 16'($urandom), 16'($urandom), 0, 0, -1, -1, -1, 0);
    for (int r = 0; r < 4; r++) begin
      run40($sformatf("rand%0d", r), 16'($urandom), 16'($urandom), 16'($urandom),
            0, 1, (r == 3) ? int'($urandom_range(0, L - 1)) : -1, -1, -1, 0);
    end
    run1("len1_8000", 16'h8000);
    run1("len1_rand", 16'($urandom) & 16'h7FFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dsp_config_loader.md
Name: dsp_config_loader

Overview:
- Drives the serial configuration chain threaded through the DSP block and its sub-blocks: `configuration_input` at the head, `configuration_enable` to every element, `configuration_output` returned from the tail.
- Accepts parallel configuration words from a host over a valid/ready handshake and serialises them MSB-first into the chain.
- Then recirculates the chain once, computing a CRC to verify the load without disturbing the contents.
- Sits between the host/config bus and the DSP tile or column.

Parameters:
- WORD_W, 16, width of host configuration word.
- CHAIN_LEN, 64, total number of flops in the serial chain (≥1).
- CNT_W, 16, width of bit counters; must satisfy 2^CNT_W > CHAIN_LEN.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- RSTN  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a load; ignored unless IDLE.
- abort  in  1  synchronous abort; highest priority after reset.
- cfg_word  in  WORD_W  configuration word, MSB shifted first.
- cfg_valid  in  1  cfg_word valid.
- cfg_ready  out  1  loader can accept cfg_word this cycle.
- configuration_input  out  1  serial data to chain head.
- configuration_enable  out  1  chain shift enable.
- configuration_output  in  1  serial data from chain tail.
- busy  out  1  high in LOAD or VERIFY.
- done  out  1  one-cycle pulse on completion of VERIFY.
- crc_error  out  1  sticky until next start; valid when done pulses.
- bit_count  out  CNT_W  bits shifted in the current phase.

Behaviour:
- Reset (RSTN low, asynchronous): state IDLE. cfg_ready, configuration_input, configuration_enable, busy, done, crc_error = 0. bit_count = 0. Holding and shift registers cleared. CRC = 0xFFFF. Chain contents are undefined after reset; a full reload is required.
- States:
  - IDLE: start → LOAD. On entry, clear crc_error and bit_count, and set both CRC accumulators to 0xFFFF.
  - LOAD: serialise CHAIN_LEN bits. After the last bit → VERIFY with bit_count cleared.
  - VERIFY: CHAIN_LEN recirculation cycles → IDLE with a done pulse.
- Buffering: one holding register plus one WORD_W shift register.
  - cfg_ready = 1 in LOAD while the holding register is empty and words remain to be accepted.
  - Transfer occurs on cfg_valid & cfg_ready.
  - Word count = ceil(CHAIN_LEN/WORD_W). cfg_ready stays 0 once the last word is accepted, and is 0 in IDLE and VERIFY.
- LOAD shifting: on each cycle where the shift register holds bits, present the next bit on configuration_input with configuration_enable = 1 (both registered). bit_count increments.
  - An empty shift register is refilled from the holding register with no bubble.
  - If no data is available, configuration_enable = 0 and the chain holds.
  - Trailing unused low bits of the final word are discarded. Exactly CHAIN_LEN enable cycles occur.
- Load CRC: CRC-16-CCITT, polynomial 0x1021, init 0xFFFF, bit-serial, updated with each bit driven during LOAD.
- VERIFY: configuration_enable = 1 for exactly CHAIN_LEN consecutive cycles.
  - configuration_input is driven combinationally from configuration_output (pure recirculation, so the loop adds no flop).
  - A second CRC absorbs configuration_output on each enabled edge; the tail presents bits in load order.
  - After the final cycle, crc_error = (verify CRC ≠ load CRC) and done pulses the same cycle, while the state returns to IDLE.
  - Recirculation leaves the chain contents unchanged.
- Abort (any state): next edge → IDLE. configuration_enable = 0, cfg_ready = 0, no done pulse, crc_error unchanged. Chain contents are undefined.
- Simultaneous events:
  - start while busy is ignored.
  - abort and start in the same cycle: abort wins.
  - abort takes priority over a handshake in the same cycle; the word is not consumed.
- Latency: first enable cycle occurs 1 cycle after the first word handshake. With zero stalls, total start-to-done = CHAIN_LEN (load) + CHAIN_LEN (verify) + 2 cycles.

Test Plan:
- WORD_W=16, CHAIN_LEN=40, chain modelled as a 40-flop shift register. Start, then words 0xA5C3, 0x0F0F, 0x1234 with no stalls → exactly 40 LOAD enable cycles; chain holds 0xA5C30F0F12 (first bit at the tail); 40 VERIFY cycles; done pulse; crc_error=0; chain still 0xA5C30F0F12.
- Same sequence with cfg_valid low for 3 cycles before word 2 → configuration_enable low for exactly those 3 cycles; bit_count frozen at 16; final contents and crc_error=0 unchanged.
- Model flips chain bit 7 between LOAD and VERIFY → crc_error=1 at done; done still pulses once.
- Assert abort at bit_count=20 in LOAD → IDLE next cycle, enable=0, busy=0, no done. A subsequent start reloads correctly with crc_error=0.
- Pulse RSTN low mid-VERIFY → all outputs 0 immediately (asynchronously). Start pulses during busy in other runs are ignored: no restart and no bit_count reset.
- CHAIN_LEN=1, WORD_W=16, word 0x8000 → one LOAD enable cycle; chain=1; one VERIFY cycle; crc_error=0.
